// File: rtl/vrf_stream_if.sv
// Streaming vector register file bus: flattened read-stream channels plus one write stream.
// wr_mask exists only when VRF_MASK_EN is defined.
interface vrf_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REG    = 8,
  parameter int NUM_ELE    = 32,
  parameter int NUM_RD     = 2,
  parameter int REG_AW     = $clog2(NUM_REG),
  parameter int VL_W       = $clog2(NUM_ELE) + 1
);
  logic [NUM_RD-1:0]            rd_start;
  logic [NUM_RD*REG_AW-1:0]     rd_reg;
  logic [NUM_RD*VL_W-1:0]       rd_vl;
  logic [NUM_RD-1:0]            rd_busy;
  logic [NUM_RD-1:0]            rd_valid;
  logic [NUM_RD-1:0]            rd_ready;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_last;

  logic                         wr_start;
  logic [REG_AW-1:0]            wr_reg;
  logic [VL_W-1:0]              wr_vl;
  logic                         wr_busy;
  logic                         wr_ready;
  logic                         wr_valid;
  logic [DATA_WIDTH-1:0]        wr_data;
`ifdef VRF_MASK_EN
  logic                         wr_mask;
`endif
  logic                         wr_done;

  modport master (
    output rd_start, rd_reg, rd_vl, rd_ready,
    output wr_start, wr_reg, wr_vl, wr_valid, wr_data,
`ifdef VRF_MASK_EN
    output wr_mask,
`endif
    input  rd_busy, rd_valid, rd_data, rd_last,
    input  wr_busy, wr_ready, wr_done
  );

  modport slave (
    input  rd_start, rd_reg, rd_vl, rd_ready,
    input  wr_start, wr_reg, wr_vl, wr_valid, wr_data,
`ifdef VRF_MASK_EN
    input  wr_mask,
`endif
    output rd_busy, rd_valid, rd_data, rd_last,
    output wr_busy, wr_ready, wr_done
  );
endinterface

// File: rtl/vrf_stream.sv
// Streaming vector register file: NUM_RD read-stream channels and one write stream.
// Optional VRF_MASK_EN adds a per-beat write enable (wr_mask).
//   state     | meaning
//   RD_IDLE   | read channel waiting for a valid rd_start
//   RD_STREAM | read channel presenting element idx of reg_q
//   WR_IDLE   | write channel waiting for a valid wr_start
//   WR_ACTIVE | write channel accepting beats into wr_reg_q[wr_idx]
module vrf_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REG    = 8,
  parameter int NUM_ELE    = 32,
  parameter int NUM_RD     = 2,
  parameter int REG_AW     = $clog2(NUM_REG),
  parameter int VL_W       = $clog2(NUM_ELE) + 1
) (
  input  logic        clk,
  input  logic        reset,
  vrf_stream_if.slave bus
);

  localparam int              IDX_W  = (NUM_ELE > 1) ? $clog2(NUM_ELE) : 1;
  localparam logic [VL_W-1:0] MAX_VL = VL_W'(NUM_ELE);

  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;
  typedef enum logic {WR_IDLE, WR_ACTIVE} wr_state_t;

  function automatic logic reg_ok(input logic [REG_AW-1:0] r);
    return int'(r) < NUM_REG;
  endfunction

  function automatic logic [VL_W-1:0] clamp_vl(input logic [VL_W-1:0] v);
    return (int'(v) > NUM_ELE) ? MAX_VL : v;
  endfunction

  logic [DATA_WIDTH-1:0] mem [NUM_REG][NUM_ELE];

  wr_state_t         wr_state, wr_state_nxt;
  logic [REG_AW-1:0] wr_reg_q;
  logic [VL_W-1:0]   wr_vl_q;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_done_q;
  logic              wr_go, wr_beat, wr_final, wr_we;

  assign wr_go    = bus.wr_start && reg_ok(bus.wr_reg) && (bus.wr_vl != '0);
  assign wr_beat  = (wr_state == WR_ACTIVE) && bus.wr_valid;
  assign wr_final = wr_beat && ((int'(wr_idx) + 1) == int'(wr_vl_q));
`ifdef VRF_MASK_EN
  // masked beats still advance idx and count toward vl
  assign wr_we    = wr_beat && bus.wr_mask;
`else
  assign wr_we    = wr_beat;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_state <= WR_IDLE;
    else       wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      WR_IDLE:   if (wr_go)    wr_state_nxt = WR_ACTIVE;
      WR_ACTIVE: if (wr_final) wr_state_nxt = WR_IDLE;
      default:                 wr_state_nxt = WR_IDLE;
    endcase
  end

  always_comb begin
    bus.wr_busy  = (wr_state == WR_ACTIVE);
    bus.wr_ready = (wr_state == WR_ACTIVE);
    bus.wr_done  = wr_done_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_reg_q  <= '0;
      wr_vl_q   <= '0;
      wr_idx    <= '0;
      wr_done_q <= 1'b0;
    end else begin
      wr_done_q <= wr_final;
      if ((wr_state == WR_IDLE) && wr_go) begin
        wr_reg_q <= bus.wr_reg;
        wr_vl_q  <= clamp_vl(bus.wr_vl);
        wr_idx   <= '0;
      end else if (wr_beat) begin
        wr_idx   <= wr_idx + 1'b1;
      end
    end
  end

  // Reads sample mem before this edge's write lands: no same-edge bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REG; r++)
        for (int e = 0; e < NUM_ELE; e++)
          mem[r][e] <= '0;
    end else if (wr_we) begin
      mem[wr_reg_q][wr_idx] <= bus.wr_data;
    end
  end

  for (genvar ch = 0; ch < NUM_RD; ch++) begin : g_rd
    rd_state_t             state, state_nxt;
    logic [REG_AW-1:0]     reg_in, reg_q;
    logic [VL_W-1:0]       vl_in, vl_q;
    logic [IDX_W-1:0]      idx, idx_inc;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  go, hs, at_last, busy, last;

    assign reg_in  = bus.rd_reg[ch*REG_AW +: REG_AW];
    assign vl_in   = bus.rd_vl[ch*VL_W +: VL_W];
    assign go      = bus.rd_start[ch] && reg_ok(reg_in) && (vl_in != '0);
    assign hs      = (state == RD_STREAM) && bus.rd_ready[ch];
    assign at_last = (int'(idx) + 1) == int'(vl_q);
    assign idx_inc = idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RD_IDLE;
      else       state <= state_nxt;
    end

    always_comb begin
      state_nxt = state;
      case (state)
        RD_IDLE:   if (go)            state_nxt = RD_STREAM;
        RD_STREAM: if (hs && at_last) state_nxt = RD_IDLE;
        default:                      state_nxt = RD_IDLE;
      endcase
    end

    always_comb begin
      busy = (state == RD_STREAM);
      last = busy && at_last;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        reg_q  <= '0;
        vl_q   <= '0;
        idx    <= '0;
        data_q <= '0;
      end else if ((state == RD_IDLE) && go) begin
        reg_q  <= reg_in;
        vl_q   <= clamp_vl(vl_in);
        idx    <= '0;
        data_q <= mem[reg_in][0];
      end else if (hs && !at_last) begin
        idx    <= idx_inc;
        data_q <= mem[reg_q][idx_inc];
      end
    end

    assign bus.rd_busy[ch]                           = busy;
    assign bus.rd_valid[ch]                          = busy;
    assign bus.rd_last[ch]                           = last;
    assign bus.rd_data[ch*DATA_WIDTH +: DATA_WIDTH]  = data_q;
  end

endmodule

// File: tb/tb_vrf_stream.sv
// Directed bench for vrf_stream: hand-computed expectations checked at each call site.
// A second, small instance exercises out-of-range register indices.
module tb_vrf_stream;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vrf_stream_if #(.DATA_WIDTH(32), .NUM_REG(8), .NUM_ELE(32), .NUM_RD(2)) bus ();
  vrf_stream #(.DATA_WIDTH(32), .NUM_REG(8), .NUM_ELE(32), .NUM_RD(2)) u_dut (
    .clk(clk), .reset(reset), .bus(bus));

  vrf_stream_if #(.DATA_WIDTH(8), .NUM_REG(6), .NUM_ELE(4), .NUM_RD(1)) sbus ();
  vrf_stream #(.DATA_WIDTH(8), .NUM_REG(6), .NUM_ELE(4), .NUM_RD(1)) u_small (
    .clk(clk), .reset(reset), .bus(sbus));

  logic [31:0] v3_exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] v1_exp [4] = '{32'hA, 32'h0, 32'hC, 32'h0};

  task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_go(input int ch, input logic [2:0] r, input logic [5:0] vl);
    bus.rd_reg[ch*3 +: 3] = r;
    bus.rd_vl[ch*6 +: 6]  = vl;
    bus.rd_start[ch]      = 1'b1;
  endtask

  task automatic wr_go(input logic [2:0] r, input logic [5:0] vl);
    bus.wr_reg   = r;
    bus.wr_vl    = vl;
    bus.wr_start = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.rd_start = '0; bus.rd_reg = '0; bus.rd_vl = '0; bus.rd_ready = '0;
    bus.wr_start = 1'b0; bus.wr_reg = '0; bus.wr_vl = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0;
    sbus.rd_start = '0; sbus.rd_reg = '0; sbus.rd_vl = '0; sbus.rd_ready = '0;
    sbus.wr_start = 1'b0; sbus.wr_reg = '0; sbus.wr_vl = '0;
    sbus.wr_valid = 1'b0; sbus.wr_data = '0;
`ifdef VRF_MASK_EN
    bus.wr_mask = 1'b1;
    sbus.wr_mask = 1'b1;
`endif

    tick();
    chk("rst rd_busy",  bus.rd_busy  === 2'b00, bus.rd_busy,  2'b00);
    chk("rst rd_valid", bus.rd_valid === 2'b00, bus.rd_valid, 2'b00);
    chk("rst rd_last",  bus.rd_last  === 2'b00, bus.rd_last,  2'b00);
    chk("rst rd_data",  bus.rd_data  === 64'h0, bus.rd_data,  64'h0);
    chk("rst wr_busy",  bus.wr_busy  === 1'b0,  bus.wr_busy,  1'b0);
    chk("rst wr_ready", bus.wr_ready === 1'b0,  bus.wr_ready, 1'b0);
    chk("rst wr_done",  bus.wr_done  === 1'b0,  bus.wr_done,  1'b0);
    reset = 1'b0;
    tick();

    wr_go(3'd3, 6'd4);
    tick();
    bus.wr_start = 1'b0;
    chk("wr busy",  bus.wr_busy  === 1'b1, bus.wr_busy,  1'b1);
    chk("wr ready", bus.wr_ready === 1'b1, bus.wr_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = v3_exp[k];
      tick();
      if (k < 3) chk("wr_done early", bus.wr_done === 1'b0, bus.wr_done, 1'b0);
    end
    bus.wr_valid = 1'b0;
    chk("wr_done pulse", bus.wr_done === 1'b1, bus.wr_done, 1'b1);
    chk("wr busy end",   bus.wr_busy === 1'b0, bus.wr_busy, 1'b0);
    tick();
    chk("wr_done one cycle", bus.wr_done === 1'b0, bus.wr_done, 1'b0);

    bus.rd_ready = 2'b11;
    rd_go(0, 3'd3, 6'd4);
    tick();
    bus.rd_start = '0;
    for (int k = 0; k < 4; k++) begin
      chk("rd0 valid", bus.rd_valid[0] === 1'b1, bus.rd_valid[0], 1'b1);
      chk("rd0 data",  bus.rd_data[31:0] === v3_exp[k], bus.rd_data[31:0], v3_exp[k]);
      chk("rd0 last",  bus.rd_last[0] === 1'(k == 3), bus.rd_last[0], 1'(k == 3));
      chk("rd1 idle",  bus.rd_busy[1] === 1'b0, bus.rd_busy[1], 1'b0);
      tick();
    end
    chk("rd0 busy end",  bus.rd_busy[0]  === 1'b0, bus.rd_busy[0],  1'b0);
    chk("rd0 valid end", bus.rd_valid[0] === 1'b0, bus.rd_valid[0], 1'b0);

    begin
      int k;
      k = 0;
      rd_go(0, 3'd3, 6'd4);
      tick();
      bus.rd_start = '0;
      for (int c = 0; c < 7; c++) begin
        chk("bp valid", bus.rd_valid[0] === 1'b1, bus.rd_valid[0], 1'b1);
        chk("bp data",  bus.rd_data[31:0] === v3_exp[k], bus.rd_data[31:0], v3_exp[k]);
        chk("bp last",  bus.rd_last[0] === 1'(k == 3), bus.rd_last[0], 1'(k == 3));
        bus.rd_ready[0] = (c % 2 == 0);
        tick();
        if (c % 2 == 0) k++;
      end
      chk("bp busy end", bus.rd_busy[0] === 1'b0, bus.rd_busy[0], 1'b0);
      bus.rd_ready[0] = 1'b1;
    end

    wr_go(3'd2, 6'd40);
    tick();
    bus.wr_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'(k + 1);
      tick();
    end
    bus.wr_valid = 1'b0;
    chk("wr clamp done", bus.wr_done === 1'b1, bus.wr_done, 1'b1);
    chk("wr clamp busy", bus.wr_busy === 1'b0, bus.wr_busy, 1'b0);
    rd_go(1, 3'd2, 6'd40);
    tick();
    bus.rd_start = '0;
    for (int k = 0; k < 32; k++) begin
      chk("clamp data", bus.rd_data[63:32] === 32'(k + 1), bus.rd_data[63:32], 32'(k + 1));
      chk("clamp last", bus.rd_last[1] === 1'(k == 31), bus.rd_last[1], 1'(k == 31));
      tick();
    end
    chk("clamp busy end", bus.rd_busy[1] === 1'b0, bus.rd_busy[1], 1'b0);

    rd_go(0, 3'd3, 6'd0);
    wr_go(3'd3, 6'd0);
    tick();
    bus.rd_start = '0;
    bus.wr_start = 1'b0;
    chk("vl0 rd busy",  bus.rd_busy[0]  === 1'b0, bus.rd_busy[0],  1'b0);
    chk("vl0 rd valid", bus.rd_valid[0] === 1'b0, bus.rd_valid[0], 1'b0);
    chk("vl0 wr busy",  bus.wr_busy     === 1'b0, bus.wr_busy,     1'b0);

    sbus.rd_ready = 1'b1;
    sbus.rd_start = 1'b1; sbus.rd_reg = 3'd7; sbus.rd_vl = 3'd2;
    tick();
    chk("oor rd reg7", sbus.rd_busy === 1'b0, sbus.rd_busy, 1'b0);
    sbus.rd_reg = 3'd6;
    tick();
    sbus.rd_start = 1'b0;
    chk("oor rd reg6", sbus.rd_busy === 1'b0, sbus.rd_busy, 1'b0);
    sbus.wr_start = 1'b1; sbus.wr_reg = 3'd6; sbus.wr_vl = 3'd2;
    tick();
    sbus.wr_start = 1'b0;
    chk("oor wr reg6", sbus.wr_busy === 1'b0, sbus.wr_busy, 1'b0);
    sbus.rd_start = 1'b1; sbus.rd_reg = 3'd5; sbus.rd_vl = 3'd2;
    tick();
    sbus.rd_start = 1'b0;
    chk("in-range rd busy", sbus.rd_busy === 1'b1, sbus.rd_busy, 1'b1);
    tick();
    chk("in-range rd last", sbus.rd_last === 1'b1, sbus.rd_last, 1'b1);
    tick();
    chk("in-range rd done", sbus.rd_busy === 1'b0, sbus.rd_busy, 1'b0);

    rd_go(0, 3'd3, 6'd4);
    tick();
    chk("sib e0", bus.rd_data[31:0] === 32'h11, bus.rd_data[31:0], 32'h11);
    rd_go(0, 3'd2, 6'd1);
    tick();
    bus.rd_start = '0;
    chk("sib e1", bus.rd_data[31:0] === 32'h22, bus.rd_data[31:0], 32'h22);
    tick();
    chk("sib e2", bus.rd_data[31:0] === 32'h33, bus.rd_data[31:0], 32'h33);
    tick();
    chk("sib e3", bus.rd_data[31:0] === 32'h44, bus.rd_data[31:0], 32'h44);
    chk("sib last", bus.rd_last[0] === 1'b1, bus.rd_last[0], 1'b1);
    tick();
    chk("sib busy end", bus.rd_busy[0] === 1'b0, bus.rd_busy[0], 1'b0);

    rd_go(0, 3'd3, 6'd4);
    rd_go(1, 3'd3, 6'd4);
    tick();
    bus.rd_start = '0;
    for (int k = 0; k < 4; k++) begin
      chk("dual valid", bus.rd_valid === 2'b11, bus.rd_valid, 2'b11);
      chk("dual data0", bus.rd_data[31:0]  === v3_exp[k], bus.rd_data[31:0],  v3_exp[k]);
      chk("dual data1", bus.rd_data[63:32] === v3_exp[k], bus.rd_data[63:32], v3_exp[k]);
      tick();
    end
    chk("dual busy end", bus.rd_busy === 2'b00, bus.rd_busy, 2'b00);

    wr_go(3'd3, 6'd3);
    tick();
    bus.wr_start = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h11;
    rd_go(0, 3'd3, 6'd4);
    tick();
    bus.rd_start = '0;
    chk("col e0", bus.rd_data[31:0] === 32'h11, bus.rd_data[31:0], 32'h11);
    bus.wr_data = 32'h22;
    tick();
    chk("col e1", bus.rd_data[31:0] === 32'h22, bus.rd_data[31:0], 32'h22);
    bus.wr_data = 32'h99;
    tick();
    bus.wr_valid = 1'b0;
    chk("col old value", bus.rd_data[31:0] === 32'h33, bus.rd_data[31:0], 32'h33);
    chk("col wr_done", bus.wr_done === 1'b1, bus.wr_done, 1'b1);
    tick();
    chk("col e3", bus.rd_data[31:0] === 32'h44, bus.rd_data[31:0], 32'h44);
    tick();
    chk("col busy end", bus.rd_busy[0] === 1'b0, bus.rd_busy[0], 1'b0);
    rd_go(0, 3'd3, 6'd4);
    tick();
    bus.rd_start = '0;
    tick();
    tick();
    chk("col new value", bus.rd_data[31:0] === 32'h99, bus.rd_data[31:0], 32'h99);
    tick();
    tick();
    chk("col reread end", bus.rd_busy[0] === 1'b0, bus.rd_busy[0], 1'b0);

`ifdef VRF_MASK_EN
    wr_go(3'd1, 6'd4);
    tick();
    bus.wr_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'(10 + k);
      bus.wr_mask  = (k % 2 == 0);
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.wr_mask  = 1'b1;
    chk("mask wr_done", bus.wr_done === 1'b1, bus.wr_done, 1'b1);
    rd_go(0, 3'd1, 6'd4);
    tick();
    bus.rd_start = '0;
    for (int k = 0; k < 4; k++) begin
      chk("mask data", bus.rd_data[31:0] === v1_exp[k], bus.rd_data[31:0], v1_exp[k]);
      tick();
    end
    chk("mask rd end", bus.rd_busy[0] === 1'b0, bus.rd_busy[0], 1'b0);
`endif

    rd_go(0, 3'd2, 6'd32);
    tick();
    bus.rd_start = '0;
    tick();
    tick();
    wr_go(3'd3, 6'd4);
    tick();
    bus.wr_start = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h55;
    tick();
    bus.wr_data = 32'h66;
    tick();
    chk("pre-rst elem5", bus.rd_data[31:0] === 32'h6, bus.rd_data[31:0], 32'h6);
    chk("pre-rst wr_ready", bus.wr_ready === 1'b1, bus.wr_ready, 1'b1);
    bus.wr_data = 32'h77;
    #2 reset = 1'b1;
    #1;
    chk("mid rst rd_busy",  bus.rd_busy  === 2'b00, bus.rd_busy,  2'b00);
    chk("mid rst rd_valid", bus.rd_valid === 2'b00, bus.rd_valid, 2'b00);
    chk("mid rst rd_last",  bus.rd_last  === 2'b00, bus.rd_last,  2'b00);
    chk("mid rst rd_data",  bus.rd_data  === 64'h0, bus.rd_data,  64'h0);
    chk("mid rst wr_busy",  bus.wr_busy  === 1'b0,  bus.wr_busy,  1'b0);
    chk("mid rst wr_ready", bus.wr_ready === 1'b0,  bus.wr_ready, 1'b0);
    chk("mid rst wr_done",  bus.wr_done  === 1'b0,  bus.wr_done,  1'b0);
    bus.wr_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    rd_go(0, 3'd3, 6'd4);
    rd_go(1, 3'd2, 6'd4);
    tick();
    bus.rd_start = '0;
    for (int k = 0; k < 4; k++) begin
      chk("post-rst valid", bus.rd_valid === 2'b11, bus.rd_valid, 2'b11);
      chk("post-rst v3", bus.rd_data[31:0]  === 32'h0, bus.rd_data[31:0],  32'h0);
      chk("post-rst v2", bus.rd_data[63:32] === 32'h0, bus.rd_data[63:32], 32'h0);
      tick();
    end
    wr_go(3'd1, 6'd1);
    tick();
    bus.wr_start = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hAB;
    tick();
    bus.wr_valid = 1'b0;
    chk("post-rst wr_done", bus.wr_done === 1'b1, bus.wr_done, 1'b1);
    rd_go(1, 3'd1, 6'd1);
    tick();
    bus.rd_start = '0;
    chk("post-rst rd data", bus.rd_data[63:32] === 32'hAB, bus.rd_data[63:32], 32'hAB);
    chk("post-rst rd last", bus.rd_last[1] === 1'b1, bus.rd_last[1], 1'b1);
    tick();
    chk("post-rst rd end", bus.rd_busy[1] === 1'b0, bus.rd_busy[1], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
